// File: rtl/pingpang_reader.sv
// Read-side master for the ping-pong ADC frame buffer: frames w_cs_n, toggles w_dclk, captures w_miso.
// Optional PINGPANG_READER_AUTO_EN: after the first start, frames repeat back-to-back until reset.
module pingpang_reader #(
  parameter int WIDTH       = 12,
  parameter int FRAME_LEN   = 1024,
  parameter int CNT_W       = 16,
  parameter int DCLK_DIV    = 4,
  parameter int LEAD_CYCLES = 8,
  parameter int GAP_CYCLES  = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  output logic             o_w_cs_n,
  output logic             o_w_dclk,
  input  logic [WIDTH-1:0] i_w_miso,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_dout_valid,
  output logic [CNT_W-1:0] o_word_cnt,
  output logic             o_busy,
  output logic             o_frame_done
);

  localparam int MAX_DL = (DCLK_DIV > LEAD_CYCLES) ? DCLK_DIV : LEAD_CYCLES;
  localparam int MAX_PH = (MAX_DL > GAP_CYCLES) ? MAX_DL : GAP_CYCLES;
  localparam int PH_W   = $clog2(MAX_PH + 1);

  // Phase counter is loaded with N-1 so each state lasts exactly N cycles.
  localparam logic [PH_W-1:0]  PH_LEAD   = PH_W'(LEAD_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_DCLK   = PH_W'(DCLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_GAP    = PH_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_LEN);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_CLK_HI, S_CLK_LO, S_GAP} state_t;

  state_t            r_state, w_state_nxt;
  logic [PH_W-1:0]   r_ph, w_ph_nxt;
  logic              r_cs_n, w_cs_n_nxt;
  logic              r_dclk, w_dclk_nxt;
  logic [WIDTH-1:0]  r_dout, w_dout_nxt;
  logic              r_valid, w_valid_nxt;
  logic [CNT_W-1:0]  r_word_cnt, w_cnt_nxt, w_cnt_inc;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_ph       <= '0;
      r_cs_n     <= 1'b1;
      r_dclk     <= 1'b0;
      r_dout     <= '0;
      r_valid    <= 1'b0;
      r_word_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ph       <= w_ph_nxt;
      r_cs_n     <= w_cs_n_nxt;
      r_dclk     <= w_dclk_nxt;
      r_dout     <= w_dout_nxt;
      r_valid    <= w_valid_nxt;
      r_word_cnt <= w_cnt_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ph_nxt    = (r_ph != '0) ? r_ph - PH_W'(1) : r_ph;
    w_cs_n_nxt  = r_cs_n;
    w_dclk_nxt  = r_dclk;
    w_dout_nxt  = r_dout;
    w_valid_nxt = 1'b0;
    w_cnt_nxt   = r_word_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_cnt_inc   = r_word_cnt + CNT_W'(1);
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_LEAD;
          w_ph_nxt    = PH_LEAD;
          w_cs_n_nxt  = 1'b0;
          w_dclk_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      S_LEAD: begin
        if (r_ph == '0) begin
          w_state_nxt = S_CLK_HI;
          w_ph_nxt    = PH_DCLK;
          w_dclk_nxt  = 1'b1;
        end
      end
      S_CLK_HI: begin
        if (r_ph == '0) begin
          w_state_nxt = S_CLK_LO;
          w_ph_nxt    = PH_DCLK;
          w_dclk_nxt  = 1'b0;
        end
      end
      S_CLK_LO: begin
        // Capture on the last low cycle; the final word lands with frame_done.
        if (r_ph == '0) begin
          w_dout_nxt  = i_w_miso;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = w_cnt_inc;
          if (w_cnt_inc == LAST_WORD) begin
            w_state_nxt = S_GAP;
            w_ph_nxt    = PH_GAP;
            w_cs_n_nxt  = 1'b1;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_CLK_HI;
            w_ph_nxt    = PH_DCLK;
            w_dclk_nxt  = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (r_ph == '0) begin
`ifdef PINGPANG_READER_AUTO_EN
          w_state_nxt = S_LEAD;
          w_ph_nxt    = PH_LEAD;
          w_cs_n_nxt  = 1'b0;
          w_cnt_nxt   = '0;
`else
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_w_cs_n     = r_cs_n;
  assign o_w_dclk     = r_dclk;
  assign o_dout       = r_dout;
  assign o_dout_valid = r_valid;
  assign o_word_cnt   = r_word_cnt;
  assign o_busy       = r_busy;
  assign o_frame_done = r_done;

endmodule

// File: tb/tb_pingpang_reader.sv
// Self-checking bench for pingpang_reader: two instances (4-word and 1-word frames) checked every
// cycle against a frame-offset arithmetic model, plus literal expectations for the directed cases.
module tb_pingpang_reader;
  localparam int W  = 12;
  localparam int CW = 16;
  localparam int AL = 4, AD = 2, AFL = 4, AG = 8;
  localparam int BL = 4, BD = 1, BFL = 1, BG = 8;
`ifdef PINGPANG_READER_AUTO_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [W-1:0] miso = '0;
  logic a_cs_n, a_dclk, a_valid, a_busy, a_fd;
  logic b_cs_n, b_dclk, b_valid, b_busy, b_fd;
  logic [W-1:0] a_dout, b_dout;
  logic [CW-1:0] a_wc, b_wc;

  pingpang_reader #(.WIDTH(W), .FRAME_LEN(AFL), .CNT_W(CW), .DCLK_DIV(AD),
                    .LEAD_CYCLES(AL), .GAP_CYCLES(AG)) u_a (
    .i_clk(clk), .i_reset(rst), .i_start(start), .o_w_cs_n(a_cs_n), .o_w_dclk(a_dclk),
    .i_w_miso(miso), .o_dout(a_dout), .o_dout_valid(a_valid), .o_word_cnt(a_wc),
    .o_busy(a_busy), .o_frame_done(a_fd));

  pingpang_reader #(.WIDTH(W), .FRAME_LEN(BFL), .CNT_W(CW), .DCLK_DIV(BD),
                    .LEAD_CYCLES(BL), .GAP_CYCLES(BG)) u_b (
    .i_clk(clk), .i_reset(rst), .i_start(start), .o_w_cs_n(b_cs_n), .o_w_dclk(b_dclk),
    .i_w_miso(miso), .o_dout(b_dout), .o_dout_valid(b_valid), .o_word_cnt(b_wc),
    .o_busy(b_busy), .o_frame_done(b_fd));

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual=0x%0h required=0x%0h", name, cyc, act, req);
    end
  endtask

  // Model: each frame is described only by the cycle its w_cs_n went low.
  bit           m_on[2];
  int           m_s[2];
  logic [W-1:0] m_dout[2];
  logic [W-1:0] miso_prev = '0;

  task automatic model_check(input int id, input string nm, input int L, input int D,
                             input int FL, input int G, input logic csn, input logic dclk,
                             input logic [W-1:0] dout, input logic valid,
                             input logic [CW-1:0] wc, input logic busy, input logic fd);
    int fw, t, e_wc;
    bit e_csn, e_dclk, e_valid, e_busy, e_fd;
    fw = FL * 2 * D;
    t = 0;
    e_csn = 1'b1; e_dclk = 1'b0; e_valid = 1'b0; e_busy = 1'b0; e_fd = 1'b0; e_wc = 0;
    if (rst) begin
      m_on[id] = 1'b0;
      m_dout[id] = '0;
    end else if (m_on[id]) begin
      t = cyc - m_s[id];
      if (AUTO) t = t % (L + fw + G);
      e_csn   = !(t < L + fw);
      e_dclk  = (t >= L) && (t < L + fw) && (((t - L) % (2 * D)) < D);
      e_valid = (t >= L + 2 * D) && (t <= L + fw) && (((t - L) % (2 * D)) == 0);
      e_fd    = (t == L + fw);
      e_busy  = AUTO || (t < L + fw + G);
      e_wc    = (t < L) ? 0 : (t - L) / (2 * D);
      if (e_wc > FL) e_wc = FL;
      if (e_valid) m_dout[id] = miso_prev;
    end
    cmp({nm, ".cs_n"}, int'(csn), int'(e_csn));
    cmp({nm, ".dclk"}, int'(dclk), int'(e_dclk));
    cmp({nm, ".dout_valid"}, int'(valid), int'(e_valid));
    cmp({nm, ".frame_done"}, int'(fd), int'(e_fd));
    cmp({nm, ".busy"}, int'(busy), int'(e_busy));
    cmp({nm, ".word_cnt"}, int'(wc), e_wc);
    cmp({nm, ".dout"}, int'(dout), int'(m_dout[id]));
    if (!rst && start && (!m_on[id] || (!AUTO && t >= L + fw + G))) begin
      m_on[id] = 1'b1;
      m_s[id]  = cyc + 1;
    end
  endtask

  int a_low = 0, a_rise = 0, a_vcnt = 0, a_fdcnt = 0;
  int b_vcnt = 0, b_fdcnt = 0, b_same = 0;
  logic a_dclk_n = 1'b0;
  logic [W-1:0] a_words[$];
`ifdef PINGPANG_READER_AUTO_EN
  int gap_runs[$], frame_v[$];
  int gaprun = 0, vc = 0, frames_seen = 0;
  logic a_csn_last = 1'b1;
`endif

  always @(negedge clk) begin
    model_check(0, "A", AL, AD, AFL, AG, a_cs_n, a_dclk, a_dout, a_valid, a_wc, a_busy, a_fd);
    model_check(1, "B", BL, BD, BFL, BG, b_cs_n, b_dclk, b_dout, b_valid, b_wc, b_busy, b_fd);
    miso_prev = miso;
    if (rst) begin
      a_dclk_n = 1'b0;
`ifdef PINGPANG_READER_AUTO_EN
      a_csn_last = 1'b1; gaprun = 0;
`endif
    end else begin
      if (!a_cs_n) a_low++;
      if (a_dclk && !a_dclk_n) a_rise++;
      a_dclk_n = a_dclk;
      if (a_valid) begin a_vcnt++; a_words.push_back(a_dout); end
      if (a_fd) a_fdcnt++;
      if (b_valid) b_vcnt++;
      if (b_fd) b_fdcnt++;
      if (b_valid && b_fd) b_same++;
`ifdef PINGPANG_READER_AUTO_EN
      if (!a_cs_n && a_csn_last) begin
        if (frames_seen > 0) frame_v.push_back(vc);
        frames_seen++;
        vc = 0;
        if (gaprun > 0) gap_runs.push_back(gaprun);
        gaprun = 0;
      end
      if (a_cs_n && a_busy) gaprun++;
      if (a_valid) vc++;
      a_csn_last = a_cs_n;
`endif
    end
  end

  // Pattern mode: 0x100+k is presented after the k-th rising w_dclk of instance A.
  bit   rnd_miso = 1'b0;
  int   drv_k = 0;
  logic drv_last = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rnd_miso) miso = W'($urandom);
    else if (a_dclk && !drv_last) begin
      miso = W'(32'h100 + drv_k);
      drv_k++;
    end
    drv_last = a_dclk;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic clear_stats();
    a_low = 0; a_rise = 0; a_vcnt = 0; a_fdcnt = 0; a_words.delete();
    b_vcnt = 0; b_fdcnt = 0; b_same = 0; drv_k = 0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (a_busy && k < 400) begin tick(); k++; end
    cmp({nm, ".timeout"}, (k < 400) ? 0 : 1, 0);
  endtask

  task automatic check_frame(input string nm);
    cmp({nm, ".cs_low_cycles"}, a_low, 20);
    cmp({nm, ".dclk_rises"}, a_rise, 4);
    cmp({nm, ".valid_pulses"}, a_vcnt, 4);
    cmp({nm, ".frame_done"}, a_fdcnt, 1);
    cmp({nm, ".word_cnt"}, int'(a_wc), 4);
    for (int i = 0; i < a_words.size() && i < 4; i++)
      cmp({nm, ".word"}, int'(a_words[i]), 32'h100 + i);
  endtask

  initial begin
    #1 rst = 1'b1;
    tick(3);
    cmp("rst.cs_n", int'(a_cs_n), 1);
    cmp("rst.dclk", int'(a_dclk), 0);
    cmp("rst.dout", int'(a_dout), 0);
    cmp("rst.valid", int'(a_valid), 0);
    cmp("rst.busy", int'(a_busy), 0);
    cmp("rst.word_cnt", int'(a_wc), 0);
    cmp("rst.frame_done", int'(a_fd), 0);
    rst = 1'b0;
    tick(2);
`ifndef PINGPANG_READER_AUTO_EN
    clear_stats();
    pulse_start();
    wait_idle("f1");
    tick();
    check_frame("f1");
    cmp("f1.b_valid", b_vcnt, 1);
    cmp("f1.b_frame_done", b_fdcnt, 1);
    cmp("f1.b_done_with_capture", b_same, 1);
    cmp("f1.b_dout", int'(b_dout), 32'h100);

    clear_stats();
    pulse_start();
    tick(6);
    pulse_start();
    begin
      int k = 0;
      while (!a_fd && k < 100) begin tick(); k++; end
      cmp("f2.fd_timeout", (k < 100) ? 0 : 1, 0);
    end
    tick(3);
    pulse_start();
    wait_idle("f2");
    tick();
    check_frame("f2");
    tick(3);
    cmp("f2.no_queue_cs_n", int'(a_cs_n), 1);
    cmp("f2.no_queue_busy", int'(a_busy), 0);

    clear_stats();
    pulse_start();
    tick(2);
    cmp("f3.word_cnt_restart", int'(a_wc), 0);
    begin
      int k = 0;
      while (a_rise < 3 && k < 100) begin tick(); k++; end
      cmp("f3.rise_timeout", (k < 100) ? 0 : 1, 0);
    end
    cmp("f3.in_clk_hi", int'(a_dclk), 1);
    rst = 1'b1;
    #1;
    cmp("f3.rst_cs_n", int'(a_cs_n), 1);
    cmp("f3.rst_dclk", int'(a_dclk), 0);
    cmp("f3.rst_busy", int'(a_busy), 0);
    tick();
    rst = 1'b0;
    tick(3);
    cmp("f3.no_frame_done", a_fdcnt, 0);
    cmp("f3.partial_valids", a_vcnt, 2);

    clear_stats();
    pulse_start();
    wait_idle("f4");
    tick();
    check_frame("f4");
`else
    pulse_start();
    tick(3 * (AL + AFL * 2 * AD + AG) + 10);
    cmp("auto.busy", int'(a_busy), 1);
    cmp("auto.gap_count_ok", (gap_runs.size() >= 2) ? 1 : 0, 1);
    cmp("auto.frame_count_ok", (frame_v.size() >= 2) ? 1 : 0, 1);
    foreach (gap_runs[i]) cmp("auto.gap_len", gap_runs[i], AG);
    foreach (frame_v[i]) cmp("auto.frame_words", frame_v[i], AFL);
`endif

    rnd_miso = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      tick();
    end
    start = 1'b0;
    rst   = 1'b0;
    tick(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
